// File: rtl/fft_spi_master.sv
// SPI initiator for the FFT frame link: shifts FRAME_BITS out MSB-first on mosi and captures
// FRAME_BITS from miso. Optional abort support is enabled by defining FFT_SPI_MASTER_ABORT_EN.
module fft_spi_master #(
   parameter int unsigned FRAME_BITS = 1024,
   parameter int unsigned CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [FRAME_BITS-1:0] tx_frame_i,
   input  logic                  miso_i,
`ifdef FFT_SPI_MASTER_ABORT_EN
   input  logic                  abort_i,
   output logic                  aborted_o,
`endif
   output logic                  sck_o,
   output logic                  cs_o,
   output logic                  mosi_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [FRAME_BITS-1:0] rx_frame_o
);

   localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
   localparam int unsigned DivW = $clog2(CLK_DIV + 1);

   typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold} state_e;

   state_e                state_q;
   logic [DivW-1:0]       div_q;
   logic [BitW-1:0]       bit_cnt_q;
   logic [FRAME_BITS-1:0] tx_sh_q;
   logic [FRAME_BITS-1:0] rx_sh_q;
   logic [FRAME_BITS-1:0] rx_frame_q;
   logic                  sck_q;
   logic                  cs_q;
   logic                  mosi_q;
   logic                  busy_q;
   logic                  done_q;

   logic [FRAME_BITS-1:0] tx_next;
   logic [FRAME_BITS-1:0] rx_next;
   logic [BitW-1:0]       bit_inc;
   logic                  div_end;
   logic                  abort_req;
   logic                  abort_hit;
   logic                  start_ok;

`ifdef FFT_SPI_MASTER_ABORT_EN
   logic aborted_q;
   assign abort_req = abort_i;
   assign aborted_o = aborted_q;
`else
   assign abort_req = 1'b0;
`endif

   // Abort only matters during a transfer, but still masks a same-cycle start in idle.
   assign abort_hit = abort_req & busy_q;
   assign start_ok  = start_i & ~abort_req;
   assign div_end   = (div_q == DivW'(CLK_DIV - 1));
   assign bit_inc   = bit_cnt_q + BitW'(1);

   always_comb begin
      tx_next    = tx_sh_q << 1;
      rx_next    = rx_sh_q << 1;
      rx_next[0] = miso_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         div_q      <= '0;
         bit_cnt_q  <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_frame_q <= '0;
         sck_q      <= 1'b0;
         cs_q       <= 1'b0;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef FFT_SPI_MASTER_ABORT_EN
         aborted_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef FFT_SPI_MASTER_ABORT_EN
         aborted_q <= 1'b0;
`endif
         if (abort_hit) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FFT_SPI_MASTER_ABORT_EN
            aborted_q <= 1'b1;
`endif
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start_ok) begin
                     tx_sh_q   <= tx_frame_i;
                     mosi_q    <= tx_frame_i[FRAME_BITS-1];
                     rx_sh_q   <= '0;
                     cs_q      <= 1'b1;
                     busy_q    <= 1'b1;
                     div_q     <= '0;
                     bit_cnt_q <= '0;
                     state_q   <= StSetup;
                  end
               end
               StSetup: begin
                  if (div_end) begin
                     div_q   <= '0;
                     sck_q   <= 1'b1;
                     rx_sh_q <= rx_next;
                     state_q <= StHigh;
                  end else begin
                     div_q <= div_q + DivW'(1);
                  end
               end
               StHigh: begin
                  if (div_end) begin
                     div_q     <= '0;
                     sck_q     <= 1'b0;
                     bit_cnt_q <= bit_inc;
                     // After the final bit mosi keeps its value through the tail.
                     if (bit_inc != BitW'(FRAME_BITS)) begin
                        tx_sh_q <= tx_next;
                        mosi_q  <= tx_next[FRAME_BITS-1];
                     end
                     state_q <= StLow;
                  end else begin
                     div_q <= div_q + DivW'(1);
                  end
               end
               StLow: begin
                  if (div_end) begin
                     div_q <= '0;
                     if (bit_cnt_q == BitW'(FRAME_BITS)) begin
                        state_q <= StHold;
                     end else begin
                        sck_q   <= 1'b1;
                        rx_sh_q <= rx_next;
                        state_q <= StHigh;
                     end
                  end else begin
                     div_q <= div_q + DivW'(1);
                  end
               end
               StHold: begin
                  if (div_end) begin
                     div_q      <= '0;
                     bit_cnt_q  <= '0;
                     cs_q       <= 1'b0;
                     busy_q     <= 1'b0;
                     mosi_q     <= 1'b0;
                     done_q     <= 1'b1;
                     rx_frame_q <= rx_sh_q;
                     state_q    <= StIdle;
                  end else begin
                     div_q <= div_q + DivW'(1);
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign sck_o      = sck_q;
   assign cs_o       = cs_q;
   assign mosi_o     = mosi_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign rx_frame_o = rx_frame_q;

endmodule

// File: tb/tb_fft_spi_master.sv
// Directed bench for fft_spi_master: small 8-bit instance with a slave model, plus a
// 1024-bit loopback instance.
module tb_fft_spi_master;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] tx8 = '0;
   logic       miso8;
   logic       sck8, cs8, mosi8, busy8, done8;
   logic [7:0] rx8;

   logic          startb = 1'b0;
   logic [1023:0] txb = '0;
   logic          sckb, csb, mosib, busyb, doneb;
   logic [1023:0] rxb;

`ifdef FFT_SPI_MASTER_ABORT_EN
   logic abort8 = 1'b0;
   logic aborted8;
   logic abortb = 1'b0;
   logic abortedb;
`endif

   int checks = 0;
   int errors = 0;
   int rise_cnt = 0;
   int rise_base = 0;
   int stray = 0;
   int lat;
   logic [7:0] mosi_seq = '0;
   logic [7:0] slave_word = '0;

   always #5 clk = ~clk;

   fft_spi_master #(.FRAME_BITS(8), .CLK_DIV(2)) u_dut8 (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start8),
      .tx_frame_i (tx8),
      .miso_i     (miso8),
`ifdef FFT_SPI_MASTER_ABORT_EN
      .abort_i    (abort8),
      .aborted_o  (aborted8),
`endif
      .sck_o      (sck8),
      .cs_o       (cs8),
      .mosi_o     (mosi8),
      .busy_o     (busy8),
      .done_o     (done8),
      .rx_frame_o (rx8)
   );

   fft_spi_master #(.FRAME_BITS(1024), .CLK_DIV(1)) u_dutb (
      .clk        (clk),
      .reset      (reset),
      .start_i    (startb),
      .tx_frame_i (txb),
      .miso_i     (mosib),
`ifdef FFT_SPI_MASTER_ABORT_EN
      .abort_i    (abortb),
      .aborted_o  (abortedb),
`endif
      .sck_o      (sckb),
      .cs_o       (csb),
      .mosi_o     (mosib),
      .busy_o     (busyb),
      .done_o     (doneb),
      .rx_frame_o (rxb)
   );

   // Slave model: presents slave_word MSB-first, advancing after each rising sck.
   always_comb begin
      int k;
      k = rise_cnt - rise_base;
      miso8 = (k >= 0 && k < 8) ? slave_word[7 - k] : 1'b0;
   end

   always @(posedge sck8) begin
      rise_cnt <= rise_cnt + 1;
      mosi_seq <= {mosi_seq[6:0], mosi8};
      if (!cs8) stray <= stray + 1;
   end

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch8(input logic [7:0] tx, input logic [7:0] sw);
      tx8        = tx;
      slave_word = sw;
      rise_base  = rise_cnt;
      start8     = 1'b1;
   endtask

   task automatic wait_done8(input int from, output int n);
      n = from;
      for (int i = 0; i < 200; i++) begin
         cycle();
         n++;
         if (done8) return;
      end
      n = -1;
   endtask

   task automatic wait_rises8(input int cnt, output int got);
      for (int i = 0; i < 200; i++) begin
         if (rise_cnt - rise_base == cnt) break;
         cycle();
      end
      got = rise_cnt - rise_base;
   endtask

   initial begin
      int got;
      @(negedge clk);
      repeat (3) cycle();
      reset = 1'b0;
      chk("reset_sck", 64'(sck8), 64'd0);
      chk("reset_cs", 64'(cs8), 64'd0);
      chk("reset_mosi", 64'(mosi8), 64'd0);
      chk("reset_busy", 64'(busy8), 64'd0);
      chk("reset_done", 64'(done8), 64'd0);
      chk("reset_rx", 64'(rx8), 64'h00);

      // Basic frame; tx_frame is disturbed after acceptance.
      launch8(8'hA5, 8'h3C);
      cycle();
      start8 = 1'b0;
      chk("f1_cs_rise", 64'(cs8), 64'd1);
      chk("f1_busy", 64'(busy8), 64'd1);
      chk("f1_mosi_msb", 64'(mosi8), 64'd1);
      chk("f1_sck_setup", 64'(sck8), 64'd0);
      tx8 = 8'hFF;
      wait_done8(1, lat);
      chk("f1_latency", 64'(lat), 64'd37);
      chk("f1_rx", 64'(rx8), 64'h3C);
      chk("f1_mosi_seq", 64'(mosi_seq), 64'hA5);
      chk("f1_rises", 64'(rise_cnt - rise_base), 64'd8);
      chk("f1_cs_end", 64'(cs8), 64'd0);
      chk("f1_busy_end", 64'(busy8), 64'd0);
      cycle();
      chk("f1_done_pulse", 64'(done8), 64'd0);

      // start held through most of the frame gives exactly one frame.
      launch8(8'h5A, 8'h81);
      repeat (30) cycle();
      start8 = 1'b0;
      wait_done8(30, lat);
      chk("hold_latency", 64'(lat), 64'd37);
      chk("hold_rx", 64'(rx8), 64'h81);
      repeat (4) cycle();
      chk("hold_idle", 64'(busy8), 64'd0);
      chk("hold_rises", 64'(rise_cnt - rise_base), 64'd8);

      // Back-to-back: start raised during the done cycle.
      launch8(8'h33, 8'hE7);
      cycle();
      start8 = 1'b0;
      wait_done8(1, lat);
      chk("b2b1_latency", 64'(lat), 64'd37);
      chk("b2b1_rx", 64'(rx8), 64'hE7);
      chk("b2b_cs_gap", 64'(cs8), 64'd0);
      launch8(8'hC6, 8'h1D);
      cycle();
      start8 = 1'b0;
      chk("b2b_cs_back", 64'(cs8), 64'd1);
      chk("b2b_done_once", 64'(done8), 64'd0);
      wait_done8(1, lat);
      chk("b2b2_latency", 64'(lat), 64'd37);
      chk("b2b2_rx", 64'(rx8), 64'h1D);
      chk("b2b2_mosi_seq", 64'(mosi_seq), 64'hC6);

      // Reset after the 4th rising sck.
      launch8(8'h96, 8'h69);
      cycle();
      start8 = 1'b0;
      wait_rises8(4, got);
      chk("rst_reach4", 64'(got), 64'd4);
      reset = 1'b1;
      cycle();
      chk("rst_sck", 64'(sck8), 64'd0);
      chk("rst_cs", 64'(cs8), 64'd0);
      chk("rst_mosi", 64'(mosi8), 64'd0);
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_rx", 64'(rx8), 64'h00);
      reset = 1'b0;
      launch8(8'h0F, 8'hF0);
      cycle();
      start8 = 1'b0;
      wait_done8(1, lat);
      chk("post_rst_latency", 64'(lat), 64'd37);
      chk("post_rst_rx", 64'(rx8), 64'hF0);
      chk("post_rst_mosi_seq", 64'(mosi_seq), 64'h0F);

      // 1024-bit loopback.
      for (int i = 0; i < 32; i++) txb[i*32 +: 32] = $urandom;
      startb = 1'b1;
      cycle();
      startb = 1'b0;
      lat = 1;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         lat++;
         if (doneb) break;
      end
      chk("big_latency", 64'(lat), 64'd2051);
      checks++;
      assert (rxb === txb) else begin
         errors++;
         $error("FAIL big_loopback observed=%0h expected=%0h", rxb[63:0], txb[63:0]);
      end

`ifdef FFT_SPI_MASTER_ABORT_EN
      launch8(8'hAA, 8'h55);
      cycle();
      start8 = 1'b0;
      wait_rises8(3, got);
      chk("ab_reach3", 64'(got), 64'd3);
      abort8 = 1'b1;
      cycle();
      abort8 = 1'b0;
      chk("ab_pulse", 64'(aborted8), 64'd1);
      chk("ab_cs", 64'(cs8), 64'd0);
      chk("ab_sck", 64'(sck8), 64'd0);
      chk("ab_mosi", 64'(mosi8), 64'd0);
      chk("ab_busy", 64'(busy8), 64'd0);
      chk("ab_no_done", 64'(done8), 64'd0);
      chk("ab_rx_kept", 64'(rx8), 64'hF0);
      cycle();
      chk("ab_pulse_end", 64'(aborted8), 64'd0);
      abort8 = 1'b1;
      start8 = 1'b1;
      cycle();
      abort8 = 1'b0;
      start8 = 1'b0;
      chk("ab_start_busy", 64'(busy8), 64'd0);
      chk("ab_start_cs", 64'(cs8), 64'd0);
      chk("ab_idle_no_pulse", 64'(aborted8), 64'd0);
`endif

      chk("no_stray_sck", 64'(stray), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
